prng_reseed_ctrl: RTL and testbench

Consumer-side controller for the Trivium PRNG wrapper. It drives the PRNG's reseed interface (seed, start pulse, busy monitoring) from an upstream SVRS seed channel. It acts as the SVRS sink of the PRNG's pseudo-random stream and forwards that stream to the masked core through a 2-entry registered FIFO. It sits between the seed source (TRNG or host) and the PRNG and enforces reseeding after a fixed number of consumed words.

---
 rtl/prng_reseed_ctrl.sv | 155 +++++++++++++++
 tb/tb_prng_reseed_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prng_reseed_ctrl.sv
// Purpose : reseed controller for the Trivium PRNG; takes seeds from an upstream valid/ready
//           channel, pulses the PRNG reseed start, then sinks the PRNG stream into a 2-entry FIFO.
// Latency : seed handshake t -> start pulse t+1; PRNG handshake t -> word on rnd_data at t+1.
// Backpressure: prng_out_ready depends only on FIFO occupancy (registered), never on rnd_ready.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   seed_valid/seed_ready/seed_in upstream seed channel (80-bit seed)
//   force_reseed                  one-cycle request for an immediate reseed (honoured in RUN only)
//   prng_start_reseed, prng_seed  reseed start pulse and registered seed towards the PRNG
//   prng_busy                     PRNG reseed in progress
//   prng_out_valid/_ready/_rnd    PRNG random stream (this block is the sink)
//   rnd_valid/rnd_ready/rnd_data  random stream towards the masked core (FIFO head)
//   reseeding                     high whenever the stream is not in RUN
//
// Build option: define PRNG_AUTO_RESEED_EN to add the word counter that forces a reseed every
// RESEED_PERIOD accepted words. Without it, RUN is left only on force_reseed.

module prng_reseed_ctrl #(
   parameter int RND           = 128,
   parameter int RESEED_PERIOD = 1024
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           seed_valid,
   output logic           seed_ready,
   input  logic [79:0]    seed_in,
   input  logic           force_reseed,
   output logic           prng_start_reseed,
   output logic [79:0]    prng_seed,
   input  logic           prng_busy,
   input  logic           prng_out_valid,
   output logic           prng_out_ready,
   input  logic [RND-1:0] prng_out_rnd,
   output logic           rnd_valid,
   input  logic           rnd_ready,
   output logic [RND-1:0] rnd_data,
   output logic           reseeding
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_RUN   = 3'd3;
   localparam logic [2:0] S_REQ   = 3'd4;

   logic [2:0]     state;
   logic [2:0]     state_nxt;
   logic [79:0]    seed_q;
   logic           seed_hs;
   logic           push;
   logic           pop;
   logic           expire;

   logic [RND-1:0] fifo_mem [2];
   logic           wr_ptr;
   logic           rd_ptr;
   logic [1:0]     fifo_cnt;
   logic           fifo_full;

   // ------------------------------------------------------------------
   // Handshakes and state-derived outputs (no input-to-output paths)
   // ------------------------------------------------------------------
   assign seed_ready        = (state == S_IDLE) || (state == S_REQ);
   assign seed_hs           = seed_ready && seed_valid;
   assign prng_start_reseed = (state == S_START);
   assign prng_seed         = seed_q;
   assign reseeding         = (state != S_RUN);
   assign fifo_full         = (fifo_cnt == 2'd2);
   assign prng_out_ready    = (state == S_RUN) && !fifo_full;
   assign push              = prng_out_valid && prng_out_ready;
   assign rnd_valid         = (fifo_cnt != 2'd0);
   assign pop               = rnd_valid && rnd_ready;
   assign rnd_data          = fifo_mem[rd_ptr];

   // ------------------------------------------------------------------
   // Word counter: counts accepted words since the last START. It is not
   // advanced on the expiring handshake, so it never reaches RESEED_PERIOD.
   // ------------------------------------------------------------------
`ifdef PRNG_AUTO_RESEED_EN
   localparam int               CNT_W = $clog2(RESEED_PERIOD + 1);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(RESEED_PERIOD - 1);

   logic [CNT_W-1:0] word_cnt;

   assign expire = push && (word_cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_cnt <= '0;
      end else if (state == S_START) begin
         word_cnt <= '0;
      end else if (push && !expire) begin
         word_cnt <= word_cnt + 1'b1;
      end
   end
`else
   assign expire = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (seed_hs) state_nxt = S_START;
         S_START: state_nxt = S_WAIT;
         // Both conditions in the same cycle: the PRNG has finished and has
         // its first word ready, so RUN can accept immediately.
         S_WAIT:  if (!prng_busy && prng_out_valid) state_nxt = S_RUN;
         // A coincident force and expiry collapse into one REQ entry.
         S_RUN:   if (force_reseed || expire) state_nxt = S_REQ;
         S_REQ:   if (seed_hs) state_nxt = S_START;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         seed_q <= '0;
      end else begin
         state <= state_nxt;
         if (seed_hs) begin
            seed_q <= seed_in;
         end
      end
   end

   // ------------------------------------------------------------------
   // 2-entry FIFO. Push is only possible when not full, so a same-cycle
   // push/pop never overflows; contents survive reseeds and drain freely.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            fifo_mem[i] <= '0;
         end
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         fifo_cnt <= 2'd0;
      end else begin
         if (push) begin
            fifo_mem[wr_ptr] <= prng_out_rnd;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
      end
   end

endmodule

// File: tb/tb_prng_reseed_ctrl.sv
// Bench for prng_reseed_ctrl with RND=8, RESEED_PERIOD=4. A reference model (phase plus word
// queue) predicts every output each cycle; directed literals pin key points of the sequence.
// Follows whichever PRNG_AUTO_RESEED_EN setting the design was built with.

module tb_prng_reseed_ctrl;

   localparam int RND    = 8;
   localparam int PERIOD = 4;
`ifdef PRNG_AUTO_RESEED_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   // model phases
   localparam int P_IDLE  = 0;
   localparam int P_START = 1;
   localparam int P_WAIT  = 2;
   localparam int P_RUN   = 3;
   localparam int P_REQ   = 4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           seed_valid = 1'b0;
   logic           seed_ready;
   logic [79:0]    seed_in = '0;
   logic           force_reseed = 1'b0;
   logic           prng_start_reseed;
   logic [79:0]    prng_seed;
   logic           prng_busy = 1'b0;
   logic           prng_out_valid = 1'b0;
   logic           prng_out_ready;
   logic [RND-1:0] prng_out_rnd = '0;
   logic           rnd_valid;
   logic           rnd_ready = 1'b0;
   logic [RND-1:0] rnd_data;
   logic           reseeding;

   int n_vec = 0;
   int n_err = 0;

   // reference model state
   int             m_ph  = P_IDLE;
   int             m_cnt = 0;
   logic [79:0]    m_seed = '0;
   logic [RND-1:0] m_q[$];

   always #5 clk = ~clk;

   prng_reseed_ctrl #(.RND(RND), .RESEED_PERIOD(PERIOD)) dut (
      .clk(clk), .rst_n(rst_n),
      .seed_valid(seed_valid), .seed_ready(seed_ready), .seed_in(seed_in),
      .force_reseed(force_reseed),
      .prng_start_reseed(prng_start_reseed), .prng_seed(prng_seed),
      .prng_busy(prng_busy),
      .prng_out_valid(prng_out_valid), .prng_out_ready(prng_out_ready),
      .prng_out_rnd(prng_out_rnd),
      .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd_data(rnd_data),
      .reseeding(reseeding)
   );

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_ph   = P_IDLE;
      m_cnt  = 0;
      m_seed = '0;
      m_q.delete();
   endtask

   // One clock cycle: compare all outputs against the model mid-cycle, then
   // advance the model with the inputs currently applied.
   task automatic step();
      bit   e_rdy, push, pop;
      int   nph, ncnt;
      logic [79:0] nseed;
      @(negedge clk);
      e_rdy = (m_ph == P_RUN) && (m_q.size() < 2);
      chk("seed_ready",        80'(seed_ready),        80'(m_ph == P_IDLE || m_ph == P_REQ));
      chk("reseeding",         80'(reseeding),         80'(m_ph != P_RUN));
      chk("prng_start_reseed", 80'(prng_start_reseed), 80'(m_ph == P_START));
      chk("prng_seed",         prng_seed,              m_seed);
      chk("prng_out_ready",    80'(prng_out_ready),    80'(e_rdy));
      chk("rnd_valid",         80'(rnd_valid),         80'(m_q.size() != 0));
      if (m_q.size() != 0) chk("rnd_data", 80'(rnd_data), 80'(m_q[0]));

      pop   = (m_q.size() != 0) && rnd_ready;
      push  = e_rdy && prng_out_valid;
      nph   = m_ph;
      ncnt  = m_cnt;
      nseed = m_seed;
      case (m_ph)
         P_IDLE, P_REQ: if (seed_valid) begin nph = P_START; nseed = seed_in; end
         P_START:       begin nph = P_WAIT; ncnt = 0; end
         P_WAIT:        if (!prng_busy && prng_out_valid) nph = P_RUN;
         P_RUN: begin
            if (push) ncnt = m_cnt + 1;
            if (force_reseed || (AUTO && push && ncnt == PERIOD)) nph = P_REQ;
         end
         default: nph = P_IDLE;
      endcase
      @(posedge clk);
      if (pop)  void'(m_q.pop_front());
      if (push) m_q.push_back(prng_out_rnd);
      m_ph   = nph;
      m_cnt  = ncnt;
      m_seed = nseed;
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // seed handshake from IDLE/REQ, then START, then WAIT with PRNG ready -> RUN
   task automatic reseed(input logic [79:0] s);
      seed_valid = 1'b1; seed_in = s;
      step();
      seed_valid = 1'b0;
      chk("start_pulse_lit", 80'(prng_start_reseed), 80'd1);
      chk("seed_lit", prng_seed, s);
      prng_busy = 1'b0; prng_out_valid = 1'b0;
      step();                      // START -> WAIT
      step();                      // WAIT holds (no valid)
      prng_out_valid = 1'b1;
      step();                      // WAIT -> RUN
      prng_out_valid = 1'b0;
      chk("run_lit", 80'(reseeding), 80'd0);
   endtask

   initial begin
      // reset values
      #2;
      chk("rst_seed_ready", 80'(seed_ready), 80'd1);
      chk("rst_reseeding",  80'(reseeding), 80'd1);
      chk("rst_start",      80'(prng_start_reseed), 80'd0);
      chk("rst_prng_seed",  prng_seed, 80'd0);
      chk("rst_out_ready",  80'(prng_out_ready), 80'd0);
      chk("rst_rnd_valid",  80'(rnd_valid), 80'd0);
      chk("rst_rnd_data",   80'(rnd_data), 80'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      steps(2);

      // first seed with a busy PRNG for 10 cycles
      seed_valid = 1'b1; seed_in = 80'hABCD;
      step();
      seed_valid = 1'b0;
      chk("s1_start", 80'(prng_start_reseed), 80'd1);
      chk("s1_seed",  prng_seed, 80'hABCD);
      prng_busy = 1'b1; prng_out_valid = 1'b1;
      steps(10);
      chk("s1_still_wait", 80'(reseeding), 80'd1);
      prng_busy = 1'b0;
      step();
      chk("s1_run", 80'(reseeding), 80'd0);
      chk("s1_rdy", 80'(prng_out_ready), 80'd1);

      // stream words 1..4 with the consumer always ready
      rnd_ready = 1'b1;
      for (int w = 1; w <= 4; w++) begin
         prng_out_rnd = 8'(w);
         step();
         chk("s2_word_lit", 80'(rnd_data), 80'(w));
      end
      if (AUTO) begin
         chk("s2_expired_rdy", 80'(prng_out_ready), 80'd0);
         chk("s2_expired_req", 80'(seed_ready), 80'd1);
      end else begin
         for (int w = 5; w <= 10; w++) begin
            prng_out_rnd = 8'(w);
            step();
         end
         chk("s2_no_req", 80'(reseeding), 80'd0);
         prng_out_valid = 1'b0; force_reseed = 1'b1;
         step();
         force_reseed = 1'b0;
         chk("s2_force_req", 80'(seed_ready), 80'd1);
      end
      prng_out_valid = 1'b1;
      steps(3);                    // parked in REQ, stream stalled
      prng_out_valid = 1'b0;

      // backpressure: only two words fit
      reseed(80'h1234);
      rnd_ready = 1'b0; prng_out_valid = 1'b1;
      for (int w = 1; w <= 4; w++) begin
         prng_out_rnd = 8'(w);
         step();
      end
      chk("s3_full_rdy", 80'(prng_out_ready), 80'd0);
      chk("s3_head1", 80'(rnd_data), 80'h01);
      prng_out_valid = 1'b0; rnd_ready = 1'b1;
      step();
      chk("s3_head2", 80'(rnd_data), 80'h02);
      step();
      chk("s3_empty", 80'(rnd_valid), 80'd0);

      // force after two words
      prng_out_valid = 1'b1; prng_out_rnd = 8'h33; force_reseed = 1'b1;
      step();
      force_reseed = 1'b0; prng_out_valid = 1'b0;
      chk("s4_force_req", 80'(seed_ready), 80'd1);
      step();
      reseed(80'h5555);

      // force coinciding with period expiry (plain force without the counter)
      prng_out_valid = 1'b1;
      for (int w = 1; w <= 4; w++) begin
         prng_out_rnd = 8'(8'h40 + w);
         force_reseed = (w == 4);
         step();
      end
      force_reseed = 1'b0; prng_out_valid = 1'b0;
      chk("s5_req", 80'(seed_ready), 80'd1);
      steps(3);
      force_reseed = 1'b1;         // ignored outside RUN
      step();
      force_reseed = 1'b0;
      reseed(80'h7777);

      // reset while waiting for the PRNG with one word queued
      rnd_ready = 1'b0; prng_out_valid = 1'b1; prng_out_rnd = 8'hA5;
      step();
      prng_out_valid = 1'b0; force_reseed = 1'b1;
      step();
      force_reseed = 1'b0;
      seed_valid = 1'b1; seed_in = 80'h9999;
      step();
      seed_valid = 1'b0; prng_busy = 1'b1;
      step();
      chk("s6_queued", 80'(rnd_valid), 80'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("s6_rst_valid", 80'(rnd_valid), 80'd0);
      chk("s6_rst_start", 80'(prng_start_reseed), 80'd0);
      chk("s6_rst_sready", 80'(seed_ready), 80'd1);
      chk("s6_rst_seed", prng_seed, 80'd0);
      model_reset();
      @(negedge clk); rst_n = 1'b1; prng_busy = 1'b0;
      @(posedge clk); #1;
      steps(3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
